// File: rtl/serial_subtractor.sv
// Bit-serial full subtractor: D = A - B - bin, one bit per clock, LSB first.
// Ports: clk, rst (sync, active-high), start/a/b/bin in; busy, done, d, bout out.
// Optional: define SERIAL_SUBTRACTOR_OVF_EN to add the registered signed-overflow output ovf.
module serial_subtractor #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] d,
   output logic             bout
`ifdef SERIAL_SUBTRACTOR_OVF_EN
   ,
   output logic             ovf
`endif
);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] r_sh;
   logic             br;
   logic [CNT_W-1:0] cnt;

   logic x;
   logic y;
   logic diff;
   logic brn;

   // single full-subtractor cell
   assign x    = a_sh[0];
   assign y    = b_sh[0];
   assign diff = x ^ y ^ br;
   assign brn  = (~x & y) | (~(x ^ y) & br);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         a_sh  <= '0;
         b_sh  <= '0;
         r_sh  <= '0;
         br    <= 1'b0;
         cnt   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         d     <= '0;
         bout  <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
         ovf   <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE, DONE: begin
               if (start) begin
                  a_sh  <= a;
                  b_sh  <= b;
                  br    <= bin;
                  r_sh  <= '0;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= RUN;
               end else begin
                  state <= IDLE;
               end
            end
            RUN: begin
               a_sh <= a_sh >> 1;
               b_sh <= b_sh >> 1;
               br   <= brn;
               r_sh <= {diff, r_sh[WIDTH-1:1]};
               cnt  <= cnt + 1'b1;
               if (cnt == CNT_W'(WIDTH - 1)) begin
                  // last bit: publish the full result in one step
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  d     <= {diff, r_sh[WIDTH-1:1]};
                  bout  <= brn;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                  // x/y are the operand MSBs here, diff is the result MSB
                  ovf   <= (x ^ y) & (diff ^ x);
`endif
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8).
// Directed test-plan cases plus random operations against an arithmetic model.
module tb_serial_subtractor;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         bin;
   logic         busy;
   logic         done;
   logic [W-1:0] d;
   logic         bout;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
   logic         ovf;
`endif

   int vectors = 0;
   int errs    = 0;

   logic [W-1:0] exp_d   = '0;
   logic         exp_b   = 1'b0;
   logic         exp_ovf = 1'b0;

   serial_subtractor #(.WIDTH(W), .CNT_W(4)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .bin   (bin),
      .busy  (busy),
      .done  (done),
      .d     (d),
      .bout  (bout)
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      ,
      .ovf   (ovf)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] expv);
      vectors++;
      assert (obs === expv) else begin
         errs++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Reference model: plain unsigned/signed arithmetic.
   task automatic model(input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic bi);
      int unsigned full;
      full    = int'(av) - int'(bv) - int'(bi);
      exp_d   = W'(full);
      exp_b   = (int'(av) < int'(bv) + int'(bi));
      exp_ovf = (av[W-1] != bv[W-1]) && (exp_d[W-1] != av[W-1]);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic check_result(input string tag);
      chk({tag, ".d"}, 32'(d), 32'(exp_d));
      chk({tag, ".bout"}, 32'(bout), 32'(exp_b));
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      chk({tag, ".ovf"}, 32'(ovf), 32'(exp_ovf));
`endif
   endtask

   // Called at a negedge; returns at the negedge of the done cycle.
   task automatic run_op(input string tag, input logic [W-1:0] av,
                         input logic [W-1:0] bv, input logic bi);
      int n;
      int nb;
      logic [W-1:0] prev_d;
      prev_d = d;
      a      = av;
      b      = bv;
      bin    = bi;
      start  = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      a      = W'($urandom);
      b      = W'($urandom);
      bin    = 1'($urandom);
      model(av, bv, bi);
      n  = 1;
      nb = 0;
      while (!done && n < W + 6) begin
         if (busy) nb++;
         if (d !== prev_d) begin
            chk({tag, ".hold"}, 32'(d), 32'(prev_d));
            prev_d = d;
         end
         @(negedge clk);
         n++;
      end
      chk({tag, ".latency"}, 32'(n), 32'(W + 1));
      chk({tag, ".busycyc"}, 32'(nb), 32'(W));
      chk({tag, ".busy_at_done"}, 32'(busy), 32'(0));
      check_result(tag);
   endtask

   initial begin
      int ndone;
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic         rbi;

      rst   = 1'b1;
      start = 1'b0;
      a     = '0;
      b     = '0;
      bin   = 1'b0;
      idle(2);
      chk("reset.busy", 32'(busy), 32'(0));
      chk("reset.done", 32'(done), 32'(0));
      chk("reset.d", 32'(d), 32'(0));
      chk("reset.bout", 32'(bout), 32'(0));
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      chk("reset.ovf", 32'(ovf), 32'(0));
`endif
      rst = 1'b0;
      idle(1);

      run_op("t1", 8'h5A, 8'h23, 1'b0);
      chk("t1.d_const", 32'(d), 32'h37);
      @(negedge clk);
      chk("t1.done_pulse", 32'(done), 32'(0));

      idle(1);
      run_op("t2", 8'h10, 8'h20, 1'b0);
      chk("t2.d_const", 32'(d), 32'hF0);
      chk("t2.bout_const", 32'(bout), 32'(1));

      idle(2);
      run_op("t3a", 8'h00, 8'h00, 1'b1);
      chk("t3a.d_const", 32'(d), 32'hFF);
      // start issued while in DONE: back-to-back
      run_op("t3b", 8'h05, 8'h03, 1'b0);
      chk("t3b.d_const", 32'(d), 32'h02);

      // start pulsed mid-run must be ignored
      idle(1);
      a     = 8'h40;
      b     = 8'h01;
      bin   = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      model(8'h40, 8'h01, 1'b0);
      ndone = 0;
      for (int c = 1; c <= 3 * W; c++) begin
         if (c == 4) begin
            a     = 8'hFF;
            start = 1'b1;
         end else begin
            start = 1'b0;
         end
         if (done) begin
            ndone++;
            check_result("t4");
            chk("t4.d_const", 32'(d), 32'h3F);
            chk("t4.cycle", 32'(c), 32'(W + 1));
         end
         @(negedge clk);
      end
      chk("t4.ndone", 32'(ndone), 32'(1));

      // reset mid-run
      a     = 8'h80;
      b     = 8'h01;
      bin   = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      idle(3);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("t5.busy", 32'(busy), 32'(0));
      chk("t5.done", 32'(done), 32'(0));
      chk("t5.d", 32'(d), 32'(0));
      chk("t5.bout", 32'(bout), 32'(0));
      ndone = 0;
      for (int c = 0; c < 2 * W; c++) begin
         if (done || busy) ndone++;
         @(negedge clk);
      end
      chk("t5.no_done", 32'(ndone), 32'(0));
      run_op("t5b", 8'h80, 8'h01, 1'b0);
      chk("t5b.d_const", 32'(d), 32'h7F);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      chk("t5b.ovf_const", 32'(ovf), 32'(1));
`endif

      idle(1);
      run_op("t6a", 8'h7F, 8'h01, 1'b0);
      chk("t6a.d_const", 32'(d), 32'h7E);
      idle(1);
      run_op("t6b", 8'h7F, 8'hFF, 1'b0);
      chk("t6b.d_const", 32'(d), 32'h80);
      chk("t6b.bout_const", 32'(bout), 32'(1));

      for (int i = 0; i < 30; i++) begin
         ra  = W'($urandom);
         rb  = W'($urandom);
         rbi = 1'($urandom);
         if (($urandom & 1) == 1) idle(int'($urandom_range(1, 3)));
         run_op($sformatf("rnd%0d", i), ra, rb, rbi);
      end

      idle(2);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule
